// File: rtl/odd_parity_pkg.sv
// Shared constants and types for the odd-parity serial receiver.
package odd_parity_pkg;

   // Payload width and full frame width (data plus parity bit).
   localparam int DATA_W    = 9;
   localparam int FRAME_W   = 10;

   // Counts the ten data/parity bits of a frame.
   localparam int BIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } rx_state_t;

endpackage

// File: rtl/odd_parity_chk.sv
// Odd-parity checker: flags a 10-bit word {d[8:0], p} whose count of ones
// is even. It is the inverse of the parity generator's rule, so any receiver
// of generator words can reuse it.
module odd_parity_chk
   import odd_parity_pkg::*;
(
   input  logic [FRAME_W-1:0] frame_i,
   output logic               perr_o
);

   // A good word has an odd number of ones across data and parity.
   assign perr_o = ~(^frame_i);

endmodule

// File: rtl/odd_parity_rx.sv
// Serial receiver for 10-bit odd-parity frames:
//   start(0), d[8]..d[0], parity, stop(1), one bit per clk, line idles high.
// A completed frame goes to a valid/ready output register with a parity-error
// sideband. A bad stop bit pulses frm_err. A frame that completes while the
// output is still held pulses overrun and is lost.
// Optional feature macro: PARITY_ERR_CNT_EN adds err_cnt, a saturating
// count of completed frames with a parity error.
module odd_parity_rx
   import odd_parity_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_in,
   output logic [DATA_W-1:0] rx_out_data,
   output logic              rx_out_perr,
   output logic              rx_out_valid,
   input  logic              rx_out_ready,
   output logic              frm_err,
   output logic              overrun
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   // Value of bit_cnt while the parity bit (the tenth bit) is shifted in.
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

   // Reject a zero-width error counter at elaboration.
   if (CNT_W < 1) begin : g_cnt_w_check
      $error("odd_parity_rx: CNT_W must be at least 1");
   end

   rx_state_t              state_q, state_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0]     shift_q, shift_d;

   logic [DATA_W-1:0]      data_q, data_d;
   logic                   perr_q, perr_d;
   logic                   valid_q, valid_d;
   logic                   frm_err_q, frm_err_d;
   logic                   overrun_q, overrun_d;

   logic                   frame_done;  // stop bit good this cycle
   logic                   frame_bad;   // stop bit low this cycle
   logic                   perr_w;      // parity verdict on the held frame
   logic                   load;        // completed frame enters the output

   // The shift register holds {d[8:0], p} once the frame reaches STOP.
   odd_parity_chk u_chk (
      .frame_i (shift_q),
      .perr_o  (perr_w)
   );

   // Receive state, bit counter and shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         // NOTE: use non-blocking (<=) in clocked blocks so every register
         // samples its pre-edge inputs regardless of statement order.
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // Next-state logic: detect the start bit, shift ten bits, judge the stop bit.
   always_comb begin
      // NOTE: give every variable a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      frame_done = 1'b0;
      frame_bad  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_in) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            // MSB arrives first, so shift towards the top.
            shift_d   = {shift_q[FRAME_W-2:0], rx_in};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
               state_d = STOP;
            end
         end
         STOP: begin
            // A low stop bit is a framing error, not a new start bit.
            state_d    = IDLE;
            bit_cnt_d  = '0;
            frame_done = rx_in;
            frame_bad  = ~rx_in;
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
         end
      endcase
   end

   // Output word and pulse flags: load on completion unless a held word blocks it.
   always_comb begin
      load      = frame_done && (!valid_q || rx_out_ready);
      data_d    = data_q;
      perr_d    = perr_q;
      valid_d   = valid_q;
      frm_err_d = frame_bad;
      overrun_d = frame_done && !load;
      if (load) begin
         data_d  = shift_q[FRAME_W-1:1];
         perr_d  = perr_w;
         valid_d = 1'b1;
      end else if (valid_q && rx_out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output register and one-cycle error pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q    <= '0;
         perr_q    <= 1'b0;
         valid_q   <= 1'b0;
         frm_err_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         perr_q    <= perr_d;
         valid_q   <= valid_d;
         frm_err_q <= frm_err_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_out_data  = data_q;
   assign rx_out_perr  = perr_q;
   assign rx_out_valid = valid_q;
   assign frm_err      = frm_err_q;
   assign overrun      = overrun_q;

`ifdef PARITY_ERR_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Count completed frames with bad parity, delivered or dropped; hold at full scale.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_done && perr_w && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // Parity-error counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/odd_parity_rx.md
# odd_parity_rx

Serial receiver for 10-bit odd-parity frames: 9 data bits followed by one odd-parity bit, which together form the word produced by the team's parity generator. The block deserialises the frame from a one-bit line, checks the start, stop and parity bits, and presents the 9-bit data with a parity-error flag on a valid/ready output port. It sits at the receive end of the serial link, ahead of any consumer logic.

## Interface
Parameters:
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  single clock for the whole block; every register is rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rx_in  input  1  serial line; idle high; one bit per clk.
- rx_out_data  output  9  received data bits d[8:0].
- rx_out_perr  output  1  parity-error sideband; qualified by rx_out_valid.
- rx_out_valid  output  1  output word available.
- rx_out_ready  input  1  consumer accepts the word.
- frm_err  output  1  one-cycle pulse on a bad stop bit.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.
- err_cnt  output  CNT_W  saturating parity-error count; present only with PARITY_ERR_CNT_EN.

## Operation
- Frame on rx_in, in order: start bit 0, d[8] … d[0] (MSB first), parity bit p, stop bit 1.
- State machine:
  - IDLE: rx_in==0 moves to DATA with bit_cnt=0. Otherwise stay.
  - DATA: shift rx_in into a 10-bit shift register and increment bit_cnt. After the 10th bit (bit_cnt==9) move to STOP.
  - STOP: always return to IDLE next cycle.
    - rx_in==1 completes the frame.
    - rx_in==0 pulses frm_err and discards the frame. This is not treated as a new start bit.
- Parity check: the frame is good when ^{d[8:0],p} == 1 (odd number of ones across all 10 bits). rx_out_perr = ~(^{d,p}).
- A frame with a parity error is still delivered, with rx_out_perr=1.
- Output register:
  - On a completed frame, load data and perr and set valid if (!rx_out_valid || rx_out_ready).
  - Otherwise keep the held word and pulse overrun; the new frame is lost.
- Handshake: the transfer happens on a cycle where valid && ready. valid clears on that cycle unless a new frame loads in the same cycle.
- Data and perr hold stable while valid && !ready.
- Reset values: state=IDLE, bit_cnt=0, shift register=0, rx_out_data=0, rx_out_perr=0, rx_out_valid=0, frm_err=0, overrun=0, err_cnt=0.
- Reset asserted mid-frame aborts the frame immediately. No partial output is produced.

## Timing
- The start bit is sampled at cycle 0, data and parity at cycles 1–10, and the stop bit at cycle 11.
- rx_out_valid rises at cycle 12, i.e. registered one cycle after the stop-bit sample.
- frm_err and overrun are registered pulses at cycle 12, exactly one clk wide.
- Minimum frame period is 12 cycles. A start bit is accepted in the IDLE cycle directly after STOP, so back-to-back frames need no gap.
- If a consumer pops on the same cycle that a frame completes, the new word loads with no overrun.

## Configuration
- PARITY_ERR_CNT_EN defined:
  - The err_cnt port exists.
  - err_cnt increments by 1 for each completed frame with a parity error, including frames dropped by overrun.
  - err_cnt saturates at 2^CNT_W−1.
  - Frames that fail on the stop bit are not counted.
- PARITY_ERR_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package odd_parity_pkg holds:
  - constants DATA_W=9 and FRAME_W=10;
  - the state enum type rx_state_t (IDLE, DATA, STOP);
  - the bit-counter width localparam (4 bits).
- One combinational sub-module, odd_parity_chk: input [9:0], output perr. It is the inverse check of the generator's rule and is reusable by other receivers.
- The FSM, shift register, output register and counter stay in the top module.

## Test plan
- Send d=9'h0A5 with p=1 (four data ones) and ready=1: rx_out_valid high at cycle 12 for one cycle, data=9'h0A5, perr=0.
- Send d=9'h0A5 with p=0: delivered with perr=1. With the macro, err_cnt goes 0→1.
- Send d=9'h1FF with p=0 and stop bit=0: frm_err pulses, no valid, err_cnt unchanged.
- Hold ready=0 and send frames 9'h001 then 9'h002:
  - second completion pulses overrun;
  - data stays 9'h001;
  - raising ready pops 9'h001 and valid then drops.
- With CNT_W=2, send 5 parity-error frames: err_cnt reads 1, 2, 3, 3, 3.
- Assert reset at cycle 5 of a frame, release, then send 9'h155 with correct parity: only 9'h155 is delivered, with no frm_err or overrun.
